// File: rtl/tinker_pkg.sv
// Shared constants and types for the Tinker register file and its scoreboard.
package tinker_pkg;

    localparam int              DATA_W     = 64;
    localparam int              NUM_REGS   = 32;
    localparam int              REG_ADDR_W = $clog2(NUM_REGS);
    localparam int              SP_IDX     = 31;
    localparam longint unsigned SP_RESET   = 64'd524288;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]     word_t;

endpackage

// File: rtl/tinker_sb_counter.sv
// One outstanding-write counter of the scoreboard: counts issued-but-not-yet
// written-back results for a single architectural register. It never wraps in
// either direction, so a stray extra writeback or issue cannot corrupt it.
module tinker_sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Simultaneous issue and writeback cancel out; otherwise step by one, holding at the ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc && !dec && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/tinker_regfile_sb.sv
// Tinker register file with scoreboard: NUM_RD combinational read ports, one
// clocked write port that is also forwarded to same-cycle readers, and one
// outstanding-write counter per register so the decoder can stall on RAW
// hazards while multi-cycle ALU/FPU results are still in flight.
module tinker_regfile_sb #(
    parameter int              DATA_W   = tinker_pkg::DATA_W,
    parameter int              NUM_REGS = tinker_pkg::NUM_REGS,
    parameter int              ADDR_W   = $clog2(NUM_REGS),
    parameter int              NUM_RD   = 3,
    parameter int              CNT_W    = 2,
    parameter int              SP_IDX   = tinker_pkg::SP_IDX,
    parameter longint unsigned SP_RESET = tinker_pkg::SP_RESET
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_hazard,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic                     issue_ready
);

    import tinker_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] regs     [NUM_REGS];
    logic [CNT_W-1:0]  pend_cnt [NUM_REGS];

    logic wr_valid;
    logic issue_in_range;
    logic [CNT_W-1:0] issue_cnt;

    // Indices beyond NUM_REGS exist only when NUM_REGS is not a power of two;
    // they have no storage and no counter behind them.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return int'(addr) < NUM_REGS;
    endfunction

    assign wr_valid = wr_en && in_range(wr_addr);

    // Register array: reset loads the stack pointer with the memory size and
    // clears everything else; register 0 is an ordinary writable register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= (r == SP_IDX) ? DATA_W'(SP_RESET) : '0;
            end
        end else if (wr_valid) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // A writeback landing on the issue target frees a slot in the same cycle,
    // so a saturated counter can still accept a new issue then.
    assign issue_in_range = in_range(issue_addr);
    assign issue_cnt      = issue_in_range ? pend_cnt[issue_addr] : '0;
    assign issue_ready    = !issue_in_range
                          || (issue_cnt != CNT_MAX)
                          || (wr_valid && (wr_addr == issue_addr));

    // One scoreboard counter per register; a writeback to an idle register
    // is an unscheduled write and leaves its counter at zero.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
        logic inc;
        logic dec;

        assign inc = issue_en && issue_ready && (issue_addr == ADDR_W'(r));
        assign dec = wr_en && (wr_addr == ADDR_W'(r)) && (pend_cnt[r] != '0);

        tinker_sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (inc),
            .dec   (dec),
            .cnt   (pend_cnt[r])
        );
    end

    // Read ports: the in-flight writeback is forwarded so a consumer sees it
    // in the same cycle, and the last pending writeback being forwarded
    // clears that port's hazard.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              addr_ok;
        logic              bypass;
        logic [CNT_W-1:0]  cnt_at;
        logic [DATA_W-1:0] arr_data;

        assign addr     = rd_addr[i*ADDR_W +: ADDR_W];
        assign addr_ok  = in_range(addr);
        assign bypass   = wr_valid && (wr_addr == addr);
        assign cnt_at   = addr_ok ? pend_cnt[addr] : '0;
        assign arr_data = addr_ok ? regs[addr] : '0;

        assign rd_data[i*DATA_W +: DATA_W] = !rd_en[i] ? '0
                                           : bypass    ? wr_data
                                           :             arr_data;

        assign rd_hazard[i] = rd_en[i]
                            && (cnt_at != '0)
                            && !(bypass && (cnt_at == CNT_W'(1)));
    end

endmodule

// File: tb/tb_tinker_regfile_sb.sv
// Self-checking bench for tinker_regfile_sb: directed walk through the main
// scenarios followed by a randomized run, all checked against an array-based
// model of registers and pending-write counts.
module tb_tinker_regfile_sb;

    localparam int  DW      = 64;
    localparam int  AW      = 5;
    localparam int  NR      = 32;
    localparam int  NP      = 3;
    localparam int  CMAX    = 3;
    localparam longint unsigned SPRST = 64'd524288;

    logic            clk;
    logic            reset;
    logic [NP-1:0]   rd_en;
    logic [NP*AW-1:0] rd_addr;
    logic [NP*DW-1:0] rd_data;
    logic [NP-1:0]   rd_hazard;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            issue_en;
    logic [AW-1:0]   issue_addr;
    logic            issue_ready;

    int checkCount;
    int errorCount;

    logic [DW-1:0] modelRegs [NR];
    int            modelCnt  [NR];

    tinker_regfile_sb dut (
        .clk         (clk),
        .reset       (reset),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_hazard   (rd_hazard),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .issue_en    (issue_en),
        .issue_addr  (issue_addr),
        .issue_ready (issue_ready)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [2:0] ren,
                                 input int a0, input int a1, input int a2,
                                 input logic we, input int wa, input logic [DW-1:0] wd,
                                 input logic ie, input int ia);
        reset      = rst;
        rd_en      = ren;
        rd_addr    = {AW'(a2), AW'(a1), AW'(a0)};
        wr_en      = we;
        wr_addr    = AW'(wa);
        wr_data    = wd;
        issue_en   = ie;
        issue_addr = AW'(ia);
        #2;
    endtask

    function automatic logic modelReady();
        int ia;
        ia = int'(issue_addr);
        return (modelCnt[ia] != CMAX) || (wr_en && (wr_addr == issue_addr));
    endfunction

    // Compare every output against what the model says the current inputs should produce.
    task automatic checkModel();
        for (int i = 0; i < NP; i++) begin
            int            a;
            logic [DW-1:0] expData;
            logic          expHaz;
            a = int'(rd_addr[i*AW +: AW]);
            if (!rd_en[i]) begin
                expData = '0;
                expHaz  = 1'b0;
            end else begin
                expData = (wr_en && int'(wr_addr) == a) ? wr_data : modelRegs[a];
                expHaz  = (modelCnt[a] != 0) && !(wr_en && int'(wr_addr) == a && modelCnt[a] == 1);
            end
            checkOutput($sformatf("rd_data[%0d]", i), rd_data[i*DW +: DW], expData);
            checkOutput($sformatf("rd_hazard[%0d]", i), DW'(rd_hazard[i]), DW'(expHaz));
        end
        checkOutput("issue_ready", DW'(issue_ready), DW'(modelReady()));
    endtask

    // Advance one edge and apply the same inputs to the model.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            for (int r = 0; r < NR; r++) begin
                modelRegs[r] = (r == 31) ? SPRST : '0;
                modelCnt[r]  = 0;
            end
        end else begin
            logic acc;
            logic dec;
            acc = issue_en && modelReady();
            dec = wr_en && (modelCnt[int'(wr_addr)] > 0);
            if (wr_en) modelRegs[int'(wr_addr)] = wr_data;
            if (acc) modelCnt[int'(issue_addr)] = modelCnt[int'(issue_addr)] + 1;
            if (dec) modelCnt[int'(wr_addr)] = modelCnt[int'(wr_addr)] - 1;
        end
        @(negedge clk);
    endtask

    task automatic stepChecked(input logic rst, input logic [2:0] ren,
                               input int a0, input int a1, input int a2,
                               input logic we, input int wa, input logic [DW-1:0] wd,
                               input logic ie, input int ia);
        applyStimulus(rst, ren, a0, a1, a2, we, wa, wd, ie, ia);
        checkModel();
        tick();
    endtask

    // Directed scenarios first, then a long randomized run.
    initial begin
        checkCount = 0;
        errorCount = 0;
        for (int r = 0; r < NR; r++) begin
            modelRegs[r] = '0;
            modelCnt[r]  = 0;
        end
        @(negedge clk);

        applyStimulus(1'b1, 3'b000, 0, 0, 0, 1'b0, 0, '0, 1'b0, 0);
        tick();

        applyStimulus(1'b0, 3'b011, 31, 5, 0, 1'b0, 0, '0, 1'b0, 0);
        checkOutput("reset_sp", rd_data[0 +: DW], 64'd524288);
        checkOutput("reset_r5", rd_data[DW +: DW], 64'd0);
        checkOutput("reset_disabled_port", rd_data[2*DW +: DW], 64'd0);
        checkOutput("reset_hazard", DW'(rd_hazard), 64'd0);
        checkOutput("reset_ready", DW'(issue_ready), 64'd1);
        checkModel();
        tick();

        applyStimulus(1'b0, 3'b001, 7, 0, 0, 1'b1, 7, 64'hDEAD_BEEF, 1'b0, 0);
        checkOutput("bypass_r7", rd_data[0 +: DW], 64'hDEAD_BEEF);
        checkModel();
        tick();
        applyStimulus(1'b0, 3'b001, 7, 0, 0, 1'b0, 0, '0, 1'b0, 0);
        checkOutput("array_r7", rd_data[0 +: DW], 64'hDEAD_BEEF);
        tick();

        stepChecked(1'b0, 3'b000, 0, 0, 0, 1'b0, 0, '0, 1'b1, 3);
        applyStimulus(1'b0, 3'b010, 0, 3, 0, 1'b0, 0, '0, 1'b0, 0);
        checkOutput("hazard_r3", DW'(rd_hazard[1]), 64'd1);
        tick();
        applyStimulus(1'b0, 3'b010, 0, 3, 0, 1'b1, 3, 64'd42, 1'b0, 0);
        checkOutput("hazard_r3_bypass", DW'(rd_hazard[1]), 64'd0);
        checkOutput("data_r3_bypass", rd_data[DW +: DW], 64'd42);
        tick();
        applyStimulus(1'b0, 3'b010, 0, 3, 0, 1'b0, 0, '0, 1'b0, 0);
        checkOutput("hazard_r3_done", DW'(rd_hazard[1]), 64'd0);
        tick();

        for (int k = 0; k < 3; k++) stepChecked(1'b0, 3'b001, 4, 0, 0, 1'b0, 0, '0, 1'b1, 4);
        applyStimulus(1'b0, 3'b001, 4, 0, 0, 1'b0, 0, '0, 1'b1, 4);
        checkOutput("r4_saturated_ready", DW'(issue_ready), 64'd0);
        checkOutput("r4_hazard", DW'(rd_hazard[0]), 64'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 3'b001, 4, 0, 0, 1'b1, 4, DW'(100 + k), 1'b0, 0);
            checkOutput($sformatf("r4_wb%0d_hazard", k), DW'(rd_hazard[0]), (k == 2) ? 64'd0 : 64'd1);
            checkModel();
            tick();
        end
        stepChecked(1'b0, 3'b001, 4, 0, 0, 1'b1, 4, 64'd7, 1'b0, 0);
        applyStimulus(1'b0, 3'b001, 4, 0, 0, 1'b0, 0, '0, 1'b0, 0);
        checkOutput("r4_no_underflow", DW'(rd_hazard[0]), 64'd0);
        checkOutput("r4_unscheduled_data", rd_data[0 +: DW], 64'd7);
        tick();

        stepChecked(1'b0, 3'b000, 0, 0, 0, 1'b0, 0, '0, 1'b1, 9);
        stepChecked(1'b0, 3'b100, 0, 0, 9, 1'b1, 9, 64'd55, 1'b1, 9);
        applyStimulus(1'b0, 3'b100, 0, 0, 9, 1'b0, 0, '0, 1'b0, 0);
        checkOutput("r9_hazard_kept", DW'(rd_hazard[2]), 64'd1);
        tick();
        stepChecked(1'b1, 3'b100, 0, 0, 9, 1'b0, 0, '0, 1'b0, 0);
        applyStimulus(1'b0, 3'b100, 0, 0, 9, 1'b0, 0, '0, 1'b0, 0);
        checkOutput("r9_after_reset_hazard", DW'(rd_hazard[2]), 64'd0);
        checkOutput("r9_after_reset_data", rd_data[2*DW +: DW], 64'd0);
        tick();

        applyStimulus(1'b1, 3'b000, 0, 0, 0, 1'b1, 31, 64'd5, 1'b0, 0);
        tick();
        applyStimulus(1'b0, 3'b001, 31, 0, 0, 1'b0, 0, '0, 1'b0, 0);
        checkOutput("reset_beats_write", rd_data[0 +: DW], 64'd524288);
        tick();

        for (int n = 0; n < 600; n++) begin
            logic rst;
            int   a0, a1, a2, wa, ia;
            rst = ($urandom_range(0, 99) < 2);
            a0  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NR - 1) : $urandom_range(0, 7);
            a1  = $urandom_range(0, 7);
            a2  = $urandom_range(0, 7);
            wa  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NR - 1) : $urandom_range(0, 7);
            ia  = $urandom_range(0, 7);
            stepChecked(rst, 3'($urandom_range(0, 7)), a0, a1, a2,
                        ($urandom_range(0, 9) < 4), wa, {$urandom, $urandom},
                        ($urandom_range(0, 1) == 1), ia);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
